// File: rtl/ndma_pkg.sv
// ndma_pkg: shared types for the NanoDMA read and write managers
package ndma_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } ndma_rd_state_t;

endpackage

// File: rtl/obi_bus.sv
// OBI_BUS: OBI request/response signal bundle with manager and subordinate views
interface OBI_BUS #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    req;
    logic                    gnt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    err;

    modport Manager (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
    modport Subordinate (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/ndma_sync_fifo.sv
// ndma_sync_fifo: synchronous FIFO; simultaneous push and pop allowed at any occupancy
module ndma_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // storage array, written on accepted push
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // pointers and occupancy count
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/ndma_burst_read_mgr.sv
// ndma_burst_read_mgr: OBI burst reader with outstanding requests and buffered output; NDMA_RD_ERR_EN enables bus error handling
module ndma_burst_read_mgr
    import ndma_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 16,
    parameter int MAX_OUTST  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    OBI_BUS.Manager           read_mgr
);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

    ndma_rd_state_t    state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  rem_q;
    logic [OW-1:0]     outst_q;
    logic [CW-1:0]     fifo_cnt;
    logic              fifo_full, fifo_empty;
    logic              req, fire, resp, resp_err, push, pop, drained, start_ok;
    logic              unused_sig;

    // credit rule: a request is only issued if its data is guaranteed a FIFO slot
    assign req = state_q == RUN && rem_q != '0 && 32'(outst_q) < MAX_OUTST
                 && 32'(outst_q) + 32'(fifo_cnt) < FIFO_DEPTH;
    assign fire     = req && read_mgr.gnt;
    assign resp     = read_mgr.rvalid && outst_q != '0;
    assign push     = resp && !resp_err;
    assign pop      = rvalid_o && rready_i;
    assign start_ok = state_q == IDLE && start_i;
    // empty next cycle: nothing in flight and the last entry (if any) leaves now
    assign drained  = outst_q == '0 && (fifo_empty || (fifo_cnt == CW'(1) && pop));
    assign rvalid_o = !fifo_empty;

    assign read_mgr.req   = req;
    assign read_mgr.addr  = addr_q;
    assign read_mgr.we    = 1'b0;
    assign read_mgr.be    = '1;
    assign read_mgr.wdata = '0;

`ifdef NDMA_RD_ERR_EN
    logic err_q;
    assign resp_err   = resp && read_mgr.err;
    assign err_o      = err_q;
    assign unused_sig = fifo_full;

    // sticky error, cleared by the next accepted start
    always_ff @(posedge clk_i) begin
        if (!rst_ni) err_q <= 1'b0;
        else if (start_ok) err_q <= 1'b0;
        else if (resp_err) err_q <= 1'b1;
    end
`else
    assign resp_err   = 1'b0;
    assign err_o      = 1'b0;
    assign unused_sig = fifo_full ^ read_mgr.err;
`endif

    ndma_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (push),
        .wdata (read_mgr.rdata),
        .pop   (pop),
        .rdata (rdata_o),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    // next-state and status outputs
    always_comb begin
        state_d = state_q;
        busy_o  = state_q != IDLE;
        done_o  = state_q == DONE;
        case (state_q)
            IDLE:    if (start_i) state_d = len_i == '0 ? DONE : RUN;
            RUN:     if ((fire && rem_q == LEN_W'(1)) || resp_err) state_d = DRAIN;
            DRAIN:   if (drained) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state, burst address/remaining count and outstanding-request tracking
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            outst_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                addr_q <= base_addr_i;
                rem_q  <= len_i;
            end else if (fire) begin
                addr_q <= addr_q + STEP;
                rem_q  <= rem_q - 1'b1;
            end
            if (resp_err) rem_q <= '0;
            outst_q <= outst_q + OW'(fire) - OW'(resp);
        end
    end
endmodule

// File: tb/tb_ndma_burst_read_mgr.sv
// tb_ndma_burst_read_mgr: scoreboard bench with an OBI subordinate model returning rdata = ~addr
module tb_ndma_burst_read_mgr;
    logic        clk = 0, rst_n = 0, start = 0, rready = 1;
    logic [31:0] base = 0;
    logic [15:0] len = 0;
    logic [31:0] rdata;
    logic        rvalid, busy, done, err;
    int          cyc = 0, n_chk = 0, n_fail = 0, s_cyc = 0;

    OBI_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) obi ();

    ndma_burst_read_mgr #(
        .ADDR_W(32), .DATA_W(32), .LEN_W(16), .MAX_OUTST(2), .FIFO_DEPTH(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base), .len_i(len),
        .rdata_o(rdata), .rvalid_o(rvalid), .rready_i(rready), .busy_o(busy),
        .done_o(done), .err_o(err), .read_mgr(obi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboards
    logic [31:0] exp_data[$], exp_addr[$];

    // subordinate model state
    typedef struct { int due; logic [31:0] a; } rsp_t;
    rsp_t        rq[$];
    int          lat = 1, stall_left = 0, grant_cnt = 0, last_g = -1;
    logic        gnt_en = 1;
    logic [31:0] stall_addr = '1, err_addr = '1;

    initial begin
        rsp_t r;
        obi.gnt = 0; obi.rvalid = 0; obi.rdata = 0; obi.err = 0;
        forever begin
            @(posedge clk); #1;
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                r = rq.pop_front();
                obi.rvalid = 1; obi.rdata = ~r.a; obi.err = r.a == err_addr;
            end else begin
                obi.rvalid = 0; obi.rdata = 0; obi.err = 0;
            end
            obi.gnt = gnt_en && !(obi.req && obi.addr == stall_addr && stall_left > 0);
            if (obi.req && obi.addr == stall_addr && stall_left > 0) stall_left--;
            if (obi.req && obi.gnt) begin
                grant_cnt++;
                last_g = cyc;
                rq.push_back('{due: cyc + lat, a: obi.addr});
                if (exp_addr.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_req: got addr %0h, no request expected", obi.addr);
                end else chk("req_addr", obi.addr, exp_addr.pop_front());
            end
        end
    end

    // output monitor: stream data, done pulses, OBI hold rule
    int          done_cnt = 0, done_cyc = -1, pop_cyc = -1, busy_cyc = -1;
    logic        done_err = 0, p_req = 0, p_gnt = 0;
    logic [31:0] p_addr = 0;
    initial forever begin
        @(negedge clk);
        if (rst_n && p_req && !p_gnt) begin
            chk("hold_req", obi.req, 1);
            chk("hold_addr", obi.addr, p_addr);
        end
        p_req = rst_n && obi.req; p_gnt = obi.gnt; p_addr = obi.addr;
        if (rvalid && rready) begin
            pop_cyc = cyc;
            if (exp_data.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_word: got %0h, no word expected", rdata);
            end else chk("rdata", rdata, exp_data.pop_front());
        end
        if (busy) busy_cyc = cyc;
        if (done) begin done_cnt++; done_cyc = cyc; done_err = err; end
    end

    task automatic push_burst(input logic [31:0] b, input int n_addr, input int n_words, input int skip);
        for (int i = 0; i < n_addr; i++) exp_addr.push_back(b + 32'(4 * i));
        for (int i = 0; i < n_words; i++) if (i != skip) exp_data.push_back(~(b + 32'(4 * i)));
    endtask

    task automatic start_burst(input logic [31:0] b, input logic [15:0] l);
        @(posedge clk); #1;
        base = b; len = l; start = 1; s_cyc = cyc;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_done(input int d0);
        for (int k = 0; k < 60 && done_cnt == d0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("done_pulses", done_cnt, d0 + 1);
        chk("sb_data_empty", exp_data.size(), 0);
        chk("sb_addr_empty", exp_addr.size(), 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_rvalid"}, rvalid, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_req"}, obi.req, 0);
        chk({tag, "_addr"}, obi.addr, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, g0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("rst");
        @(posedge clk); #1;
        rst_n = 1;

        // single word: req s+1, rvalid s+2, rvalid_o s+3, done s+4, busy low s+5
        push_burst(32'h2000, 1, 1, -1);
        d0 = done_cnt;
        start_burst(32'h2000, 1);
        wait_done(d0);
        chk("t1_pop_cyc", pop_cyc, s_cyc + 3);
        chk("t1_done_cyc", done_cyc, s_cyc + 4);
        chk("t1_busy_last", busy_cyc, s_cyc + 4);

        // zero-wait 4-word burst: grants on 4 consecutive cycles
        push_burst(32'h1000, 4, 4, -1);
        d0 = done_cnt; g0 = grant_cnt;
        start_burst(32'h1000, 4);
        wait_done(d0);
        chk("t2_grants", grant_cnt - g0, 4);
        chk("t2_last_grant", last_g, s_cyc + 4);

        // grant withheld 3 cycles on the second request
        stall_addr = 32'h3004; stall_left = 3;
        push_burst(32'h3000, 4, 4, -1);
        d0 = done_cnt; g0 = grant_cnt;
        start_burst(32'h3000, 4);
        wait_done(d0);
        chk("t3_grants", grant_cnt - g0, 4);
        chk("t3_stall_used", stall_left, 0);
        chk("t3_last_grant", last_g, s_cyc + 7);
        stall_addr = '1;

        // consumer stalled: credit rule caps issue at FIFO depth
        rready = 0;
        push_burst(32'h4000, 8, 8, -1);
        d0 = done_cnt; g0 = grant_cnt;
        start_burst(32'h4000, 8);
        repeat (12) @(negedge clk);
        chk("t4_grants_capped", grant_cnt - g0, 4);
        chk("t4_req_low", obi.req, 0);
        chk("t4_rvalid_o", rvalid, 1);
        chk("t4_nothing_popped", exp_data.size(), 8);
        @(posedge clk); #1;
        rready = 1;
        wait_done(d0);
        chk("t4_grants_total", grant_cnt - g0, 8);

        // zero length: no request, done the cycle after start
        d0 = done_cnt; g0 = grant_cnt;
        start_burst(32'h5000, 0);
        wait_done(d0);
        chk("t5_done_cyc", done_cyc, s_cyc + 1);
        chk("t5_no_grant", grant_cnt - g0, 0);

        // reset with two requests outstanding; late responses must be ignored
        lat = 3;
        push_burst(32'h6000, 2, 0, -1);
        g0 = grant_cnt;
        start_burst(32'h6000, 5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t6_outst_grants", grant_cnt - g0, 2);
        chk("t6_outst_cap_req", obi.req, 0);
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk_reset("t6");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_rvalid_quiet", rvalid, 0);
        end
        chk("t6_stale_consumed", rq.size(), 0);
        chk("t6_sb_addr_empty", exp_addr.size(), 0);
        lat = 1;

        // bus error on word 2 of 6
        err_addr = 32'h7004;
        d0 = done_cnt; g0 = grant_cnt;
`ifdef NDMA_RD_ERR_EN
        push_burst(32'h7000, 3, 3, 1);
        start_burst(32'h7000, 6);
        wait_done(d0);
        chk("t7_grants", grant_cnt - g0, 3);
        chk("t7_err_with_done", done_err, 1);
        err_addr = '1;
        d0 = done_cnt;
        start_burst(32'h7100, 0);
        wait_done(d0);
        chk("t7_err_cleared", done_err, 0);
`else
        push_burst(32'h7000, 6, 6, -1);
        start_burst(32'h7000, 6);
        wait_done(d0);
        chk("t7_grants", grant_cnt - g0, 6);
        chk("t7_err_ignored", done_err, 0);
        err_addr = '1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
